// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

  localparam logic [31:0] TIMEOUT_FILL = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Counts BUSY cycles and flags expiry on the TIMEOUT-th cycle without an ack.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  input  logic ack,
  output logic expire
);

  logic [7:0] tmo_cnt;

  // tmo_cnt holds the number of BUSY cycles already elapsed before this one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (!busy) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != '1) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  // An ack in the final cycle takes precedence over the abort.
  assign expire = busy & ~ack & (tmo_cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and load/store.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_DATA_RUN = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  localparam int unsigned RUN_W = $clog2(MAX_DATA_RUN + 1);

  state_t           state, state_n;
  owner_t           owner;
  logic             we_q;
  logic [RUN_W-1:0] run_cnt;
  logic             run_sat;
  logic             fetch_wins;
  logic             grant_i, grant_d;
  logic             busy;
  logic             expire;

  assign busy       = (state == BUSY_I) || (state == BUSY_D);
  assign run_sat    = (run_cnt == RUN_W'(MAX_DATA_RUN));
  // Data normally wins; a saturated data run hands one slot to the fetch.
  assign fetch_wins = if_req & (~d_req | run_sat);

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .busy  (busy),
    .ack   (mem_ack),
    .expire(expire)
  );

  always_comb begin
    state_n = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_wins) begin
          grant_i = 1'b1;
          state_n = BUSY_I;
        end else if (d_req) begin
          grant_d = 1'b1;
          state_n = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack || expire) state_n = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN_IF;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_i) begin
      owner    <= OWN_IF;
      we_q     <= 1'b0;
      mem_addr <= if_addr;
    end else if (grant_d) begin
      owner     <= OWN_D;
      we_q      <= d_we;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (state == IDLE) begin
      if (!if_req || grant_i) begin
        run_cnt <= '0;
      end else if (grant_d && !run_sat) begin
        run_cnt <= run_cnt + RUN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata <= '0;
      d_rdata  <= '0;
      err      <= 1'b0;
    end else begin
      if (state == BUSY_I) begin
        if (mem_ack) begin
          if_rdata <= mem_rdata;
        end else if (expire) begin
          if_rdata <= DATA_W'(TIMEOUT_FILL);
        end
      end
      if (state == BUSY_D && !we_q) begin
        if (mem_ack) begin
          d_rdata <= mem_rdata;
        end else if (expire) begin
          d_rdata <= DATA_W'(TIMEOUT_FILL);
        end
      end
      if (expire) err <= 1'b1;
    end
  end

  assign mem_req   = busy;
  assign mem_we    = busy & we_q;
  assign if_done   = (state == RESP) && (owner == OWN_IF);
  assign d_done    = (state == RESP) && (owner == OWN_D);
  assign stall_if  = if_req & ~if_done;
  assign stall_mem = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a simple wait-state memory model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        stall_if;
  logic        stall_mem;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .MAX_DATA_RUN(4),
    .TIMEOUT     (255)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_done  (if_done),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .stall_if (stall_if),
    .stall_mem(stall_mem),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mem_en;
  int          mem_wait;
  int          wait_cnt;
  logic [31:0] rd_value;

  assign mem_rdata = rd_value;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, output logic got_i, output logic got_d);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!if_done && !d_done && n < 600);
    got_i = if_done;
    got_d = d_done;
    check_eq({tag, "_done_seen"}, 32'(if_done | d_done), 32'd1);
  endtask

  // Memory model: acks after mem_wait wait cycles; responds 2 time units after the edge.
  initial begin
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_en) begin
        if (mem_req && !mem_ack) begin
          if (wait_cnt == mem_wait) begin
            mem_ack  = 1'b1;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end else begin
          mem_ack  = 1'b0;
          wait_cnt = 0;
        end
      end
    end
  end

  initial begin
    logic        gi, gd;
    logic [31:0] prev;
    int          nd;
    int          n;
    string       order;

    order    = "DDDDIDD";
    rst_n    = 1'b0;
    if_req   = 1'b0;
    if_addr  = '0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_addr   = '0;
    d_wdata  = '0;
    mem_ack  = 1'b0;
    mem_en   = 1'b1;
    mem_wait = 0;
    rd_value = '0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_if_done", 32'(if_done), 32'd0);
    check_eq("rst_d_done", 32'(d_done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_if_rdata", if_rdata, 32'd0);
    check_eq("rst_d_rdata", d_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single fetch, zero-wait memory.
    rd_value = 32'h8C220004;
    if_addr  = 32'h40;
    if_req   = 1'b1;
    #1;
    check_eq("f_c0_stall_if", 32'(stall_if), 32'd1);
    check_eq("f_c0_mem_req", 32'(mem_req), 32'd0);
    tick();
    check_eq("f_c1_mem_req", 32'(mem_req), 32'd1);
    check_eq("f_c1_mem_addr", mem_addr, 32'h40);
    check_eq("f_c1_mem_we", 32'(mem_we), 32'd0);
    check_eq("f_c1_stall_if", 32'(stall_if), 32'd1);
    tick();
    check_eq("f_c2_if_done", 32'(if_done), 32'd1);
    check_eq("f_c2_if_rdata", if_rdata, 32'h8C220004);
    check_eq("f_c2_mem_req", 32'(mem_req), 32'd0);
    check_eq("f_c2_stall_if", 32'(stall_if), 32'd0);
    if_req = 1'b0;
    tick();
    check_eq("f_c3_if_done", 32'(if_done), 32'd0);

    // Simultaneous fetch and load: data goes first.
    rd_value = 32'hCAFE0100;
    d_addr   = 32'h100;
    d_we     = 1'b0;
    d_req    = 1'b1;
    if_addr  = 32'h44;
    if_req   = 1'b1;
    tick();
    check_eq("both_first_addr", mem_addr, 32'h100);
    wait_done("both_first", gi, gd);
    check_eq("both_first_is_d", 32'(gd), 32'd1);
    check_eq("both_d_rdata", d_rdata, 32'hCAFE0100);
    d_req    = 1'b0;
    rd_value = 32'h24020005;
    wait_done("both_second", gi, gd);
    check_eq("both_second_is_i", 32'(gi), 32'd1);
    check_eq("both_if_rdata", if_rdata, 32'h24020005);
    if_req = 1'b0;
    tick();

    // Data run limit with the fetch held pending.
    rd_value = 32'h55AA0000;
    d_addr   = 32'h104;
    if_addr  = 32'h48;
    d_req    = 1'b1;
    if_req   = 1'b1;
    nd       = 0;
    for (int i = 0; i < 7; i++) begin
      wait_done($sformatf("run%0d", i), gi, gd);
      check_eq($sformatf("order%0d", i), gd ? 32'h44 : 32'h49, 32'(order[i]));
      if (gd) nd++;
      if (nd == 6) d_req = 1'b0;
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();

    // Store with three wait cycles.
    prev     = d_rdata;
    rd_value = 32'hFFFF0000;
    mem_wait = 3;
    d_addr   = 32'h200;
    d_wdata  = 32'h12345678;
    d_we     = 1'b1;
    d_req    = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_eq($sformatf("st_c%0d_mem_req", i), 32'(mem_req), 32'd1);
      check_eq($sformatf("st_c%0d_mem_we", i), 32'(mem_we), 32'd1);
      check_eq($sformatf("st_c%0d_mem_wdata", i), mem_wdata, 32'h12345678);
      check_eq($sformatf("st_c%0d_d_done", i), 32'(d_done), 32'd0);
    end
    tick();
    check_eq("st_c5_d_done", 32'(d_done), 32'd1);
    check_eq("st_d_rdata_kept", d_rdata, prev);
    check_eq("st_c5_mem_we", 32'(mem_we), 32'd0);
    d_req    = 1'b0;
    d_we     = 1'b0;
    mem_wait = 0;
    tick();

    // Ack in the last allowed BUSY cycle beats the timeout.
    mem_wait = 254;
    rd_value = 32'h13572468;
    if_addr  = 32'h80;
    if_req   = 1'b1;
    wait_done("late_ack", gi, gd);
    check_eq("late_ack_is_i", 32'(gi), 32'd1);
    check_eq("late_ack_err", 32'(err), 32'd0);
    check_eq("late_ack_rdata", if_rdata, 32'h13572468);
    if_req   = 1'b0;
    mem_wait = 0;
    tick();

    // Fetch that never gets an ack.
    mem_en  = 1'b0;
    if_addr = 32'h84;
    if_req  = 1'b1;
    tick();
    n = 0;
    while (mem_req && n < 400) begin
      n++;
      tick();
    end
    check_eq("tmo_busy_cycles", 32'(n), 32'd255);
    check_eq("tmo_if_done", 32'(if_done), 32'd1);
    check_eq("tmo_err", 32'(err), 32'd1);
    check_eq("tmo_if_rdata", if_rdata, 32'hDEADBEEF);
    if_req = 1'b0;
    mem_en = 1'b1;
    tick();
    rd_value = 32'h0BADF00D;
    d_addr   = 32'h108;
    d_req    = 1'b1;
    wait_done("post_tmo", gi, gd);
    check_eq("post_tmo_d_rdata", d_rdata, 32'h0BADF00D);
    check_eq("post_tmo_err_sticky", 32'(err), 32'd1);
    d_req = 1'b0;
    tick();

    // Reset in the middle of a data access, then a stray ack.
    mem_en = 1'b0;
    d_addr = 32'h300;
    d_req  = 1'b1;
    tick();
    tick();
    check_eq("mid_mem_req", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("mid_rst_mem_addr", mem_addr, 32'd0);
    check_eq("mid_rst_err", 32'(err), 32'd0);
    check_eq("mid_rst_if_rdata", if_rdata, 32'd0);
    check_eq("mid_rst_d_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_eq("stray_ack_d_done", 32'(d_done), 32'd0);
    check_eq("stray_ack_mem_req", 32'(mem_req), 32'd0);
    tick();
    check_eq("stray_ack_d_done2", 32'(d_done), 32'd0);
    check_eq("stray_ack_if_done2", 32'(if_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
